// File: rtl/mainmem_pkg.sv
// Shared types and constants for the main-memory responder.
// Exports word/address widths, latency bounds, error word, response struct.
package mainmem_pkg;

  localparam int WORD_W          = 16;
  localparam int ADDR_W          = 16;
  localparam int DEFAULT_LATENCY = 4;
  localparam int MAX_LATENCY     = 8;

  localparam logic [WORD_W-1:0] ERR_DATA = 16'hDEAD;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } mainmem_resp_t;

endpackage

// File: rtl/mainmem_responder_if.sv
// Request/response bundle between the cache arbiter and main memory.
// master: enable/wr/addr/write_data out; slave: read_* /data_valid/busy/addr_err out.
interface mainmem_responder_if;
  import mainmem_pkg::*;

  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] write_data;
  logic [WORD_W-1:0] read_data;
  logic [ADDR_W-1:0] read_addr;
  logic              data_valid;
  logic              busy;
  logic              addr_err;

  modport master (
    output enable, wr, addr, write_data,
    input  read_data, read_addr, data_valid, busy, addr_err
  );

  modport slave (
    input  enable, wr, addr, write_data,
    output read_data, read_addr, data_valid, busy, addr_err
  );

endinterface

// File: rtl/mainmem_delay_pipe.sv
// LATENCY-stage response shift register with synchronous clear.
// Ports: clk, rst, i_in (stage-0 input), o_out (last stage), o_busy (OR of valids).
module mainmem_delay_pipe
  import mainmem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic          clk,
  input  logic          rst,
  input  mainmem_resp_t i_in,
  output mainmem_resp_t o_out,
  output logic          o_busy
);

  mainmem_resp_t [LATENCY-1:0] r_stage;
  logic                        w_busy;

  // Payload only moves with a valid bit, so the last stage
  // holds the most recent returned word across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage[0].valid <= i_in.valid;
      if (i_in.valid) begin
        r_stage[0].data <= i_in.data;
        r_stage[0].addr <= i_in.addr;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i].valid <= r_stage[i-1].valid;
        if (r_stage[i-1].valid) begin
          r_stage[i].data <= r_stage[i-1].data;
          r_stage[i].addr <= r_stage[i-1].addr;
        end
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      w_busy = w_busy | r_stage[i].valid;
    end
  end

  assign o_out  = r_stage[LATENCY-1];
  assign o_busy = w_busy;

endmodule

// File: rtl/mainmem_responder.sv
// Main-memory responder: 16-bit word array, writes at the request edge,
// reads snapshot at issue and return after LATENCY cycles in order.
// Ports: clk, rst (sync, active-high), bus (mainmem_responder_if.slave).
// Option: MAINMEM_ALIGN_CHECK_EN rejects odd addresses and sets sticky addr_err.
module mainmem_responder
  import mainmem_pkg::*;
#(
  parameter int MEM_WORDS = 32768,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  mainmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [WORD_W-1:0] r_mem [MEM_WORDS];

  logic [IDX_W-1:0]  w_idx;
  logic              w_misal;
  logic              w_wr_ok;
  logic              w_rd_ok;
  mainmem_resp_t     w_req;
  mainmem_resp_t     w_out;
  logic              w_busy;

  // Upper address bits beyond the array size are dropped: index wraps.
  assign w_idx = bus.addr[IDX_W:1];

`ifdef MAINMEM_ALIGN_CHECK_EN
  logic r_addr_err;

  assign w_misal = bus.addr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else if (bus.enable && w_misal) begin
      r_addr_err <= 1'b1;
    end
  end

  assign bus.addr_err = r_addr_err;
`else
  assign w_misal      = 1'b0;
  assign bus.addr_err = 1'b0;
`endif

  assign w_wr_ok = bus.enable & bus.wr & ~rst & ~w_misal;
  assign w_rd_ok = bus.enable & ~bus.wr & ~rst;

  // No reset on the array: contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_idx] <= bus.write_data;
    end
  end

  // Combinational array read captures pre-edge contents.
  always_comb begin
    w_req.valid = w_rd_ok;
    w_req.data  = w_misal ? ERR_DATA : r_mem[w_idx];
    w_req.addr  = bus.addr;
  end

  mainmem_delay_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_in   (w_req),
    .o_out  (w_out),
    .o_busy (w_busy)
  );

  assign bus.read_data  = w_out.data;
  assign bus.read_addr  = w_out.addr;
  assign bus.data_valid = w_out.valid;
  assign bus.busy       = w_busy;

endmodule
